// File: rtl/nem_ohmux_sel_seq.sv
// Break-before-make select sequencer for a 2-input NEM relay inverting mux.
// Optional relay make-event counter enabled by NEM_SEL_SWCNT_EN.
module nem_ohmux_sel_seq #(
    parameter int BREAK_CYC = 2,
    parameter int MAKE_CYC  = 3,
    parameter int SWCNT_W   = 16
) (
    input  logic       CP,
    input  logic       RN,
    input  logic       REQ_VALID,
    input  logic [1:0] REQ_CODE,
    output logic       REQ_READY,
    output logic       S0,
    output logic       S1,
    output logic       SEL_VALID,
    output logic       ERR
`ifdef NEM_SEL_SWCNT_EN
    ,
    output logic [SWCNT_W-1:0] SW_COUNT
`endif
);

    localparam int MAXC = (BREAK_CYC > MAKE_CYC) ? BREAK_CYC : MAKE_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] BREAK_INIT = CW'(BREAK_CYC - 1);
    localparam logic [CW-1:0] MAKE_INIT  = CW'(MAKE_CYC - 1);

    if (BREAK_CYC < 1 || MAKE_CYC < 1 || SWCNT_W < 1) begin : g_bad_param
        $error("nem_ohmux_sel_seq: BREAK_CYC, MAKE_CYC and SWCNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_OFF,
        ST_BREAK,
        ST_MAKE,
        ST_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // Target selection: 00 open, 01 I0, 10 I1 (one-hot matches {S1,S0})
    logic [1:0]    tgt_q, tgt_d;
    logic          s0_d, s1_d, sv_d, err_d;
    logic          acc;
    logic [1:0]    op;

    assign REQ_READY = (state_q == ST_OFF) || (state_q == ST_HOLD);
    assign acc       = REQ_VALID & REQ_READY;
    assign op        = (REQ_CODE == 2'b11) ? 2'b00 : REQ_CODE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        s0_d    = S0;
        s1_d    = S1;
        sv_d    = SEL_VALID;
        err_d   = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                if (acc) begin
                    err_d = &REQ_CODE;
                    // Relays already open: close the target directly
                    if (op != 2'b00) begin
                        tgt_d   = op;
                        s0_d    = op[0];
                        s1_d    = op[1];
                        state_d = ST_MAKE;
                        cnt_d   = MAKE_INIT;
                    end
                end
            end
            ST_HOLD: begin
                if (acc) begin
                    err_d = &REQ_CODE;
                    if (op != tgt_q) begin
                        tgt_d   = op;
                        s0_d    = 1'b0;
                        s1_d    = 1'b0;
                        sv_d    = 1'b0;
                        state_d = ST_BREAK;
                        cnt_d   = BREAK_INIT;
                    end
                end
            end
            ST_BREAK: begin
                if (cnt_q == '0) begin
                    if (tgt_q == 2'b00) begin
                        state_d = ST_OFF;
                    end else begin
                        s0_d    = tgt_q[0];
                        s1_d    = tgt_q[1];
                        state_d = ST_MAKE;
                        cnt_d   = MAKE_INIT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_MAKE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    sv_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge CP) begin
        if (!RN) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            tgt_q     <= 2'b00;
            S0        <= 1'b0;
            S1        <= 1'b0;
            SEL_VALID <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            S0        <= s0_d;
            S1        <= s1_d;
            SEL_VALID <= sv_d;
            ERR       <= err_d;
        end
    end

`ifdef NEM_SEL_SWCNT_EN
    logic make_ev;

    // Wear tracking: one count per relay closing, saturating
    assign make_ev = (s0_d & ~S0) | (s1_d & ~S1);

    always_ff @(posedge CP) begin
        if (!RN) begin
            SW_COUNT <= '0;
        end else if (make_ev && !(&SW_COUNT)) begin
            SW_COUNT <= SW_COUNT + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nem_ohmux_sel_seq.sv
// Self-checking bench for nem_ohmux_sel_seq: directed table, timestamp model, random.
// Build with NEM_SEL_SWCNT_EN to also check the make-event counter.
module tb_nem_ohmux_sel_seq;

    localparam int B   = 2;
    localparam int M   = 3;
    localparam int SWW = 2;
    localparam int SWMAX = (1 << SWW) - 1;

    logic       CP = 1'b0;
    logic       RN = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic [1:0] REQ_CODE = 2'b00;
    logic       REQ_READY, S0, S1, SEL_VALID, ERR;
`ifdef NEM_SEL_SWCNT_EN
    logic [SWW-1:0] SW_COUNT;
`endif

    nem_ohmux_sel_seq #(
        .BREAK_CYC(B),
        .MAKE_CYC (M),
        .SWCNT_W  (SWW)
    ) dut (
        .CP       (CP),
        .RN       (RN),
        .REQ_VALID(REQ_VALID),
        .REQ_CODE (REQ_CODE),
        .REQ_READY(REQ_READY),
        .S0       (S0),
        .S1       (S1),
        .SEL_VALID(SEL_VALID),
        .ERR      (ERR)
`ifdef NEM_SEL_SWCNT_EN
        ,
        .SW_COUNT (SW_COUNT)
`endif
    );

    always #5 CP = ~CP;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference: selection target plus the absolute cycles at which the
    // relay closes, the output becomes valid and a new command is taken.
    int m_tgt = 0;
    int m_make_at = 0;
    int m_valid_at = 0;
    int m_ready_at = 0;
    bit m_rdy = 1'b0;
    bit m_s0 = 1'b0;
    bit m_s1 = 1'b0;
    bit m_sv = 1'b0;
    bit m_err = 1'b0;
    int m_cnt = 0;

    typedef struct {
        bit         rn;
        bit         v;
        logic [1:0] code;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(bit rn, bit v, logic [1:0] c, logic [4:0] e);
        vec_t r;
        r.rn = rn;
        r.v = v;
        r.code = c;
        r.exp = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input bit rn, input bit v, input logic [1:0] code);
        int op;
        bit ps0, ps1;
        RN = rn;
        REQ_VALID = v;
        REQ_CODE = code;
        @(posedge CP);
        cyc++;
        ps0 = m_s0;
        ps1 = m_s1;
        m_err = 1'b0;
        if (!rn) begin
            m_tgt = 0;
            m_make_at = 0;
            m_valid_at = 0;
            m_ready_at = 0;
            m_cnt = 0;
        end else if (v && m_rdy) begin
            op = (code == 2'd3) ? 0 : int'(code);
            m_err = (code == 2'd3);
            if (op != m_tgt) begin
                if (m_tgt == 0) begin
                    m_make_at = cyc;
                    m_valid_at = cyc + M;
                    m_ready_at = cyc + M;
                end else begin
                    m_make_at = cyc + B;
                    m_valid_at = cyc + B + M;
                    m_ready_at = (op == 0) ? cyc + B : cyc + B + M;
                end
                m_tgt = op;
            end
        end
        m_s0 = (m_tgt == 1) && (cyc >= m_make_at);
        m_s1 = (m_tgt == 2) && (cyc >= m_make_at);
        m_sv = (m_tgt != 0) && (cyc >= m_valid_at);
        m_rdy = (cyc >= m_ready_at);
        if (rn && ((m_s0 && !ps0) || (m_s1 && !ps1)) && m_cnt < SWMAX)
            m_cnt++;
        #1;
        check("model", {27'd0, S0, S1, SEL_VALID, REQ_READY, ERR},
              {27'd0, m_s0, m_s1, m_sv, m_rdy, m_err});
        if (S0 && S1) begin
            checks++;
            failures++;
            $display("FAIL both_selects cyc=%0d actual=11 required=not 11", cyc);
        end
        if (SEL_VALID && !(S0 ^ S1)) begin
            checks++;
            failures++;
            $display("FAIL valid_onehot cyc=%0d actual=%b%b required=one hot", cyc, S1, S0);
        end
`ifdef NEM_SEL_SWCNT_EN
        check("sw_model", 32'(SW_COUNT), 32'(m_cnt));
`endif
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !REQ_READY; i++) tick(1'b1, 1'b0, 2'b00);
        if (!REQ_READY) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout cyc=%0d actual=0 required=1", cyc);
        end
    endtask

    initial begin
        // exp = {S0, S1, SEL_VALID, REQ_READY, ERR}
        tbl[0]  = mk(0, 0, 2'b00, 5'b00010);
        tbl[1]  = mk(1, 0, 2'b00, 5'b00010);
        tbl[2]  = mk(1, 1, 2'b01, 5'b10000);
        tbl[3]  = mk(1, 0, 2'b00, 5'b10000);
        tbl[4]  = mk(1, 0, 2'b00, 5'b10000);
        tbl[5]  = mk(1, 0, 2'b00, 5'b10110);
        tbl[6]  = mk(1, 1, 2'b10, 5'b00000);
        tbl[7]  = mk(1, 0, 2'b00, 5'b00000);
        tbl[8]  = mk(1, 0, 2'b00, 5'b01000);
        tbl[9]  = mk(1, 0, 2'b00, 5'b01000);
        tbl[10] = mk(1, 0, 2'b00, 5'b01000);
        tbl[11] = mk(1, 0, 2'b00, 5'b01110);
        tbl[12] = mk(1, 1, 2'b10, 5'b01110);
        tbl[13] = mk(1, 1, 2'b11, 5'b00001);
        tbl[14] = mk(1, 0, 2'b00, 5'b00000);
        tbl[15] = mk(1, 0, 2'b00, 5'b00010);
        tbl[16] = mk(1, 1, 2'b00, 5'b00010);
        tbl[17] = mk(1, 1, 2'b01, 5'b10000);
        tbl[18] = mk(1, 0, 2'b00, 5'b10000);
        tbl[19] = mk(1, 0, 2'b00, 5'b10000);
        tbl[20] = mk(1, 0, 2'b00, 5'b10110);
        tbl[21] = mk(1, 1, 2'b10, 5'b00000);
        tbl[22] = mk(1, 0, 2'b00, 5'b00000);
        tbl[23] = mk(1, 0, 2'b00, 5'b01000);
        tbl[24] = mk(0, 0, 2'b00, 5'b00010);
        tbl[25] = mk(1, 1, 2'b01, 5'b10000);
        tbl[26] = mk(1, 1, 2'b10, 5'b10000);
        tbl[27] = mk(1, 1, 2'b11, 5'b10000);
        tbl[28] = mk(1, 0, 2'b00, 5'b10110);

        #1;
        for (int i = 0; i < 29; i++) begin
            tick(tbl[i].rn, tbl[i].v, tbl[i].code);
            check($sformatf("vec%0d", i),
                  {27'd0, S0, S1, SEL_VALID, REQ_READY, ERR},
                  {27'd0, tbl[i].exp});
        end

        // Abort a swap while still in the dead time
        tick(1'b1, 1'b1, 2'b10);
        tick(1'b1, 1'b0, 2'b00);
        tick(1'b0, 1'b0, 2'b00);
        check("abort_break", {29'd0, S0, S1, REQ_READY}, 32'b001);

        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)));
        end

`ifdef NEM_SEL_SWCNT_EN
        begin
            int exp_sw[5] = '{1, 2, 3, 3, 3};
            tick(1'b0, 1'b0, 2'b00);
            check("sw_reset0", 32'(SW_COUNT), 32'd0);
            for (int k = 0; k < 5; k++) begin
                tick(1'b1, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b10);
                wait_ready();
                check($sformatf("sw_seq%0d", k), 32'(SW_COUNT), 32'(exp_sw[k]));
            end
            tick(1'b0, 1'b0, 2'b00);
            check("sw_reset1", 32'(SW_COUNT), 32'd0);
        end
`else
        tick(1'b0, 1'b0, 2'b00);
        tick(1'b1, 1'b1, 2'b10);
        wait_ready();
        check("final_i1", {29'd0, S0, S1, SEL_VALID}, 32'b011);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nem_ohmux_sel_seq.md
Name: nem_ohmux_sel_seq

Overview:
Select sequencer that drives the one-hot S0/S1 inputs of the downstream 2-input NEM relay inverting mux (8-bit datapath). Enforces break-before-make: both relays open for a dead time before the new one closes. Holds the output flagged invalid until the closed relay has mechanically settled. One instance per mux; it sits between the routing/config controller and the relay mux.

Parameters:
BREAK_CYC, 2, cycles S0 and S1 are both held low before a new select closes (min 1)
MAKE_CYC, 3, cycles after a select asserts before SEL_VALID rises (relay settle; min 1)
SWCNT_W, 16, width of the switch-event counter (used only with the optional feature)

Ports:
CP  input  1  clock
RN  input  1  reset, synchronous, active-low
REQ_VALID  input  1  command valid
REQ_CODE  input  2  command: 00 open both, 01 select I0, 10 select I1, 11 illegal
REQ_READY  output  1  command accepted when REQ_VALID & REQ_READY at a CP rising edge
S0  output  1  select for I0 path of the relay mux, registered
S1  output  1  select for I1 path of the relay mux, registered
SEL_VALID  output  1  mux output settled on the current selection
ERR  output  1  one-cycle pulse on acceptance of REQ_CODE=11
SW_COUNT  output  SWCNT_W  relay make-event count (only with NEM_SEL_SWCNT_EN)

Behaviour:
- One clock (CP). Reset is synchronous and active-low (RN): sampled only at the CP rising edge.
- RN low at an edge forces the following on the next edge: state OFF, S0=0, S1=0, SEL_VALID=0, ERR=0, count cleared, SW_COUNT=0. REQ_READY is then 1 (combinational from state).
- RN low in BREAK or MAKE aborts the operation with the same result. No partial select survives.
- States:
  - OFF: both relays open.
  - BREAK: dead time.
  - MAKE: relay settling.
  - HOLD: selection stable.
- REQ_READY = 1 in OFF and HOLD, 0 in BREAK and MAKE. All other outputs are registered.
- Code 11 is treated as 00 (open both), and ERR pulses high for the one cycle after acceptance.
- Acceptance at edge t, from HOLD, different target (I0/I1 swap or open):
  - Edge t: S0=S1=0, SEL_VALID=0, state BREAK, count=BREAK_CYC-1.
  - Edge t+BREAK_CYC: for an open target, state OFF. For a select target, the target S goes to 1, state MAKE, count=MAKE_CYC-1.
  - Edge t+BREAK_CYC+MAKE_CYC: state HOLD, SEL_VALID=1.
- Acceptance at edge t, from OFF, select target: BREAK is skipped because both relays are already open.
  - Edge t: target S=1, state MAKE.
  - Edge t+MAKE_CYC: state HOLD, SEL_VALID=1.
- No-op commands: accepting the same selection in HOLD, or an open command in OFF, changes nothing. SEL_VALID does not glitch.
- Invariants:
  - S0 & S1 is never 1 on any cycle.
  - A 0→1 transition on S0 or S1 is always preceded by at least BREAK_CYC cycles with both S low, unless the relays were already open in OFF.
  - SEL_VALID=1 implies state HOLD and exactly one S high.
- REQ_VALID while REQ_READY=0 is ignored (not queued). The requester must hold the command until it is accepted.
- Counter width is $clog2(max(BREAK_CYC,MAKE_CYC)+1). Parameter values below 1 are an elaboration error.

Optional Feature:
NEM_SEL_SWCNT_EN:
- Defined: SW_COUNT increments by 1 on every edge where S0 or S1 goes 0→1 (relay make event, used for wear tracking). It saturates at all-ones, holds there, and is cleared only by RN.
- Undefined: the SW_COUNT port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle, BREAK_CYC=2, MAKE_CYC=3 -> S0=S1=0, SEL_VALID=0, REQ_READY=1, ERR=0.
- From OFF, accept code 01 at edge t -> S0=1 at t. SEL_VALID=1 at t+3. REQ_READY low for cycles t..t+2. S1 stays 0.
- From HOLD on I0, accept code 10 at edge t -> S0=0 at t. Both S low through t+1. S1=1 at t+2. SEL_VALID=1 at t+5. S0&S1 never 1.
- In HOLD on I1, accept code 10 -> no output change, SEL_VALID stays 1. Accept code 11 -> ERR=1 for one cycle, both S low, state OFF at t+2, REQ_READY=1.
- Drive RN low at t+3 during an I0→I1 swap (MAKE) -> next edge S0=S1=0, SEL_VALID=0. A subsequent 01 command takes the OFF path (3 cycles to SEL_VALID).
- With NEM_SEL_SWCNT_EN and SWCNT_W=2, perform 5 alternating swaps -> SW_COUNT sequence 1,2,3,3,3. Then RN low -> SW_COUNT=0.
